ahb_subordinate: RTL and testbench
==================================

// Module: ahb_subordinate
// PURPOSE
// AHB-Lite subordinate front end: accepts AHB-Lite transfers and drives a simple
// request/stall backend (ren/wen/addr/wdata/strobe, rdata/request_stall/error).
// Sits between the AHB interconnect and a peripheral or memory. It is the
// counterpart of ahb_manager. It checks the address range, size and alignment,
// inserts wait states, and generates the two-cycle AHB ERROR response.
// PARAMETERS
// BASE_ADDR   32'h8000_0000  first byte address decoded by this subordinate
// SIZE_BYTES  32'h0000_1000  decoded span in bytes; valid = [BASE_ADDR, BASE_ADDR+SIZE_BYTES)
// PORTS
// HCLK           in   1   bus clock; all state on rising edge
// HRESETn        in   1   reset, asynchronous, active-low
// HSEL           in   1   subordinate select
// HADDR          in   32  address-phase address
// HWRITE         in   1   address-phase write(1)/read(0)
// HTRANS         in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
// HSIZE          in   3   transfer size (0=byte, 1=half, 2=word)
// HBURST         in   3   ignored (every beat handled as a single transfer)
// HWDATA         in   32  data-phase write data
// HWSTRB         in   4   data-phase byte strobes
// HREADY         in   1   muxed bus HREADY (previous data phase complete)
// HREADYOUT      out  1   this subordinate's ready
// HRESP          out  1   0=OKAY, 1=ERROR
// HRDATA         out  32  read data
// ren            out  1   backend read request
// wen            out  1   backend write request
// addr           out  32  backend byte address (latched HADDR)
// wdata          out  32  backend write data (HWDATA, passed through)
// strobe         out  4   backend byte enables
// rdata          in   32  backend read data; valid when request_stall=0
// request_stall  in   1   backend not done this cycle
// error          in   1   backend error; sampled when request_stall=0
// BEHAVIOUR
// - Clock HCLK; reset HRESETn is asynchronous, active-low. Reset values: state=IDLE,
//   HREADYOUT=1, HRESP=0, HRDATA=0, ren=wen=0, addr=0, strobe=0, and all latches cleared.
// - Valid address phase (accept) = HSEL && HREADY && HTRANS[1]. SEQ is treated as NONSEQ.
//   BUSY and IDLE get a zero-wait OKAY and cause no backend access.
// - On accept, latch HWRITE, HADDR and HSIZE. Decode error if any of these holds:
//   HADDR outside the range, HSIZE>2, or HADDR not aligned to HSIZE.
// - States: IDLE, ACCESS, ERR1, ERR2.
//   IDLE:   HREADYOUT=1, HRESP=0. Accept and no decode error -> ACCESS.
//           Accept and decode error -> ERR1.
//   ACCESS: ren=!latched HWRITE, wen=latched HWRITE, addr=latched HADDR.
//           wdata=HWDATA. strobe=HWSTRB on a write, 4'b0 on a read.
//           HREADYOUT=!request_stall. HRDATA=rdata (read only, else 0).
//           If request_stall=1, stay in ACCESS (wait state, no limit).
//           If request_stall=0 and error=1: HREADYOUT forced to 0 and HRESP=1 this
//           cycle, -> ERR2. The backend access is treated as done.
//           If request_stall=0 and error=0: OKAY completes. A simultaneous accept
//           goes to ACCESS or ERR1 by decode (back-to-back, no bubble). Otherwise -> IDLE.
//   ERR1:   Used for decode errors only. HREADYOUT=0, HRESP=1, no backend request.
//           -> ERR2.
//   ERR2:   HREADYOUT=1, HRESP=1. An address phase presented this cycle is accepted
//           normally (-> ACCESS or ERR1); otherwise -> IDLE.
// - ERROR is always two cycles: first cycle HREADYOUT=0, second cycle HREADYOUT=1.
//   HRESP=1 in both cycles. HRESP=0 in every other cycle.
// - Latency: zero-wait backend gives one data-phase cycle per transfer. Full
//   pipelining: address N+1 overlaps data N.
// - Outside ACCESS: ren=wen=0 and HRDATA=0.
// - HSEL low with HREADY high while in IDLE is ignored. A transfer in progress is
//   never aborted by HSEL/HTRANS changes.
// - Reset asserted mid-transfer abandons it immediately (async). The backend must
//   tolerate a dropped request.
// TESTING
// - Write 0x8000_0004, HWSTRB=4'hF, HWDATA=0xDEADBEEF, stall=0 -> wen=1 one cycle,
//   addr=0x8000_0004, wdata=0xDEADBEEF, strobe=4'hF, HREADYOUT=1, HRESP=0.
// - Read 0x8000_0010, stall=1 for 3 cycles, rdata=0x1234_5678 -> HREADYOUT low 3
//   cycles, then high with HRDATA=0x1234_5678.
// - Read 0x8000_1000 (out of range) -> no ren, ERR1 (HREADYOUT=0, HRESP=1), then ERR2
//   (HREADYOUT=1, HRESP=1), then HRESP=0.
// - Back-to-back NONSEQ write 0x8000_0000 then read 0x8000_0008, zero-wait -> wen then
//   ren on consecutive cycles, no idle cycle between them.
// - Backend error=1 on a write with 1 stall cycle -> stall cycle, then HREADYOUT=0 with
//   HRESP=1, then HREADYOUT=1 with HRESP=1; HSIZE=2 at 0x8000_0002 -> decode ERROR.
// - HRESETn low during ACCESS wait state -> HREADYOUT=1, HRESP=0, ren=wen=0 immediately,
//   state IDLE after release.

Source files
------------

// File: rtl/ahb_subordinate.sv
// AHB-Lite subordinate front end driving a request/stall backend with range/size/alignment decode.
// Latency: one data-phase cycle per transfer with a zero-wait backend; address N+1 overlaps data N.
// Backpressure: request_stall holds HREADYOUT low indefinitely; errors use the two-cycle ERROR response.
module ahb_subordinate #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0000_1000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  HWSTRB,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        ren,
    output logic        wen,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  strobe,
    input  logic [31:0] rdata,
    input  logic        request_stall,
    input  logic        error
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;

    logic        accept;
    logic        in_range;
    logic        misalign;
    logic        dec_err;
    logic        can_take;
    logic        unused_in;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
    assign unused_in = ^{HBURST, HTRANS[0]};

    assign accept   = HSEL && HREADY && HTRANS[1];
    assign in_range = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, HADDR} <  ({1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES}));
    assign misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign dec_err  = !in_range || (HSIZE > 3'd2) || misalign;

    // A new address phase is only taken when the current data phase is finishing OKAY or in ERR2.
    assign can_take = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                      ((state_q == ST_ACCESS) && !request_stall && !error);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        case (state_q)
            ST_ACCESS: begin
                if (!request_stall) state_d = error ? ST_ERR2 : ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (can_take && accept) begin
            state_d = dec_err ? ST_ERR1 : ST_ACCESS;
            write_d = HWRITE;
            addr_d  = HADDR;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
        end
    end

    assign addr  = addr_q;
    assign wdata = HWDATA;

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        ren       = 1'b0;
        wen       = 1'b0;
        strobe    = 4'h0;
        case (state_q)
            ST_ACCESS: begin
                ren       = !write_q;
                wen       = write_q;
                strobe    = write_q ? HWSTRB : 4'h0;
                HRDATA    = write_q ? 32'h0 : rdata;
                // Backend error is only meaningful once the backend stops stalling.
                HREADYOUT = !request_stall && !error;
                HRESP     = !request_stall && error;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_subordinate.sv
// Randomized bench for ahb_subordinate against a transaction-level response model.
module tb_ahb_subordinate;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        request_stall;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending access (m_acc) or remaining ERROR-response cycles (m_err: 2 = first, 1 = second).
    bit          m_acc = 0;
    bit          m_wr  = 0;
    logic [31:0] m_addr = 32'h0;
    int          m_err = 0;

    ahb_subordinate dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .ren(ren), .wen(wen), .addr(addr), .wdata(wdata), .strobe(strobe),
        .rdata(rdata), .request_stall(request_stall), .error(error)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit decode_bad(input logic [31:0] a, input logic [2:0] s);
        longint unsigned la = 64'(a);
        if (la < 64'h8000_0000 || la >= 64'h8000_1000) return 1'b1;
        if (s > 3'd2) return 1'b1;
        if ((la % (64'd1 << s)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h8000_1000;
            1:       return 32'h7FFF_FFFC;
            2:       return $urandom;
            3:       return 32'h8000_0FFF;
            default: return 32'h8000_0000 + ($urandom & 32'h0000_0FFF);
        endcase
    endfunction

    task automatic step_random();
        bit          e_rdy, e_resp, e_ren, e_wen;
        logic [31:0] e_rd;
        logic [3:0]  e_strb;
        @(negedge HCLK);
        HSEL          = ($urandom_range(0, 9) != 0);
        HTRANS        = 2'($urandom);
        HWRITE        = 1'($urandom);
        HSIZE         = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        HADDR         = pick_addr();
        HBURST        = 3'($urandom);
        HWDATA        = $urandom;
        HWSTRB        = 4'($urandom);
        rdata         = $urandom;
        request_stall = ($urandom_range(0, 2) == 0);
        error         = ($urandom_range(0, 7) == 0);

        e_rdy = 1; e_resp = 0; e_ren = 0; e_wen = 0; e_rd = 32'h0; e_strb = 4'h0;
        if (m_err == 2) begin
            e_rdy = 0; e_resp = 1;
        end else if (m_err == 1) begin
            e_resp = 1;
        end else if (m_acc) begin
            e_ren  = !m_wr;
            e_wen  = m_wr;
            e_strb = m_wr ? HWSTRB : 4'h0;
            e_rd   = m_wr ? 32'h0 : rdata;
            if (request_stall) e_rdy = 0;
            else if (error) begin e_rdy = 0; e_resp = 1; end
        end
        HREADY = e_rdy;
        if (!m_acc && m_err == 0 && $urandom_range(0, 4) == 0) HREADY = 1'b0;

        #1;
        chk("hreadyout", HREADYOUT, e_rdy);
        chk("hresp", HRESP, e_resp);
        chk("hrdata", HRDATA, e_rd);
        chk("ren", ren, e_ren);
        chk("wen", wen, e_wen);
        chk("strobe", strobe, e_strb);
        chk("wdata", wdata, HWDATA);
        if (m_acc) chk("addr", addr, m_addr);

        if (m_err == 2) m_err = 1;
        else if (m_acc && request_stall) begin end
        else if (m_acc && error) begin m_acc = 0; m_err = 1; end
        else begin
            m_acc = 0; m_err = 0;
            if (HSEL && HREADY && HTRANS[1]) begin
                if (decode_bad(HADDR, HSIZE)) m_err = 2;
                else begin m_acc = 1; m_wr = HWRITE; m_addr = HADDR; end
            end
        end
    endtask

    initial begin
        HRESETn = 0; HSEL = 0; HADDR = 0; HWRITE = 0; HTRANS = 0; HSIZE = 0; HBURST = 0;
        HWDATA = 0; HWSTRB = 0; HREADY = 1; rdata = 0; request_stall = 0; error = 0;
        #3;
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_ren", ren, 0);
        chk("rst_wen", wen, 0);
        chk("rst_addr", addr, 0);
        chk("rst_strobe", strobe, 0);
        #9 HRESETn = 1;

        for (int i = 0; i < 3000; i++) step_random();

        // Drain to idle with no new address phases.
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            HSEL = 0; HTRANS = 0; request_stall = 0; error = 0; HREADY = 1;
        end
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2; HWRITE = 0; HADDR = 32'h8000_0010; HSIZE = 2; HREADY = 1;
        @(negedge HCLK);
        HTRANS = 0; HREADY = 0; request_stall = 1; rdata = 32'h1234_5678;
        #1;
        chk("wait_hreadyout", HREADYOUT, 0);
        chk("wait_ren", ren, 1);
        chk("wait_addr", addr, 32'h8000_0010);
        #2 HRESETn = 0;
        #1;
        chk("arst_hreadyout", HREADYOUT, 1);
        chk("arst_hresp", HRESP, 0);
        chk("arst_ren", ren, 0);
        chk("arst_wen", wen, 0);
        chk("arst_hrdata", HRDATA, 0);
        @(negedge HCLK);
        HRESETn = 1; request_stall = 0; HREADY = 1; HSEL = 0;
        @(negedge HCLK);
        #1;
        chk("post_rst_ren", ren, 0);
        chk("post_rst_hreadyout", HREADYOUT, 1);
        chk("post_rst_hresp", HRESP, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
